// File: rtl/fft_iter_pkg.sv
// fft_iter_pkg: shared constants, state codes and elaboration-time helpers for fft_iter
package fft_iter_pkg;
  localparam int BF_LAT = 2;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, COMPUTE = 2'd2, UNLOAD = 2'd3;
  localparam real PI = 3.14159265358979323846;
  function automatic int tw_cos(input int k, input int n, input int w);
    return int'($cos(2.0 * PI * k / n) * (2.0 ** (w - 1) - 1.0));
  endfunction
  function automatic int tw_sin(input int k, input int n, input int w);
    return int'($sin(2.0 * PI * k / n) * (2.0 ** (w - 1) - 1.0));
  endfunction
  function automatic logic [7:0] bit_rev(input logic [7:0] v, input int bits);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < bits; i++) r[bits-1-i] = v[i];
    return r;
  endfunction
endpackage

// File: rtl/fft_iter_butterfly.sv
// fft_butterfly: two-stage pipelined radix-2 butterfly with rounding, optional halving and saturation
module fft_butterfly #(
  parameter int DW = 16,
  parameter int TW = 16,
  parameter int TAG_W = 8,
  parameter bit SCALE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 valid_out,
  output logic [2*DW-1:0]      a_out,
  output logic [2*DW-1:0]      b_out,
  output logic [TAG_W-1:0]     tag_out,
  output logic                 ovf_out
);
  localparam int PW = DW + TW + 1;
  localparam int TT = DW + 1;
  localparam int SS = DW + 2;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW - 2);
  localparam logic signed [SS-1:0] MAXV = SS'((1 << (DW - 1)) - 1);
  localparam logic signed [SS-1:0] MINV = ~MAXV;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [TT-1:0] t_re, t_im;
  logic signed [DW-1:0] ar, ai;
  logic [TAG_W-1:0] tag1;
  logic v1;
  logic signed [SS-1:0] s [4];
  logic signed [SS-1:0] d [4];
  logic [DW:0] q [4];
  // Rounded complex product B*W, kept one bit wider than the data
  always_comb begin
    p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + RND;
    p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + RND;
  end
  // Sum/difference, optional halving, then clip to the data range with a clip bit on top
  always_comb begin
    s[0] = SS'(ar) + SS'(t_re);
    s[1] = SS'(ai) + SS'(t_im);
    s[2] = SS'(ar) - SS'(t_re);
    s[3] = SS'(ai) - SS'(t_im);
    for (int i = 0; i < 4; i++) begin
      d[i] = SCALE_EN ? s[i] >>> 1 : s[i];
      q[i] = d[i] > MAXV ? {1'b1, MAXV[DW-1:0]} : d[i] < MINV ? {1'b1, MINV[DW-1:0]} : {1'b0, d[i][DW-1:0]};
    end
  end
  // Stage 1 holds the product and A; stage 2 holds the saturated results
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1 <= 1'b0;
      t_re <= '0;
      t_im <= '0;
      ar <= '0;
      ai <= '0;
      tag1 <= '0;
      valid_out <= 1'b0;
      a_out <= '0;
      b_out <= '0;
      tag_out <= '0;
      ovf_out <= 1'b0;
    end else begin
      v1 <= valid_in;
      t_re <= TT'(p_re >>> (TW - 1));
      t_im <= TT'(p_im >>> (TW - 1));
      ar <= a_re;
      ai <= a_im;
      tag1 <= tag_in;
      valid_out <= v1;
      a_out <= {q[0][DW-1:0], q[1][DW-1:0]};
      b_out <= {q[2][DW-1:0], q[3][DW-1:0]};
      tag_out <= tag1;
      ovf_out <= v1 && (q[0][DW] || q[1][DW] || q[2][DW] || q[3][DW]);
    end
  end
endmodule

// File: rtl/fft_iter.sv
// fft_iter: iterative in-place radix-2 DIT FFT/IFFT engine around one pipelined butterfly
module fft_iter
  import fft_iter_pkg::*;
#(
  parameter int N = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH = 16,
  parameter bit SCALE_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    en,
  input  logic [2*DATA_WIDTH-1:0] cplx_data_in,
  input  logic                    inv,
  output logic                    ready,
  output logic [2*DATA_WIDTH-1:0] cplx_data_out,
  output logic                    en_out,
  output logic                    last_out,
  output logic                    ovf
);
  localparam int AW = $clog2(N);
  localparam int SW = $clog2(AW);
  localparam int DW = DATA_WIDTH;
  logic [1:0] state;
  logic [AW-1:0] cnt, span, j, k, a_addr, b_addr;
  logic [SW-1:0] st;
  logic inv_r, issue, bf_v, bf_ovf;
  logic [2*DW-1:0] mem [N];
  logic [2*DW-1:0] a_w, b_w, ya, yb;
  logic [2*AW-1:0] wtag;
  logic signed [TW_WIDTH-1:0] cos_t [N];
  logic signed [TW_WIDTH-1:0] sin_t [N];
  logic signed [TW_WIDTH-1:0] w_im;
  for (genvar i = 0; i < N; i++) begin : g_tw
    assign cos_t[i] = TW_WIDTH'(tw_cos(i, N, TW_WIDTH));
    assign sin_t[i] = TW_WIDTH'(tw_sin(i, N, TW_WIDTH));
  end
  assign a_w = mem[a_addr];
  assign b_w = mem[b_addr];
  // Butterfly addressing for the current stage: group/index split of cnt, partner at +span
  always_comb begin
    span = AW'(1) << st;
    j = cnt & (span - 1'b1);
    a_addr = (((cnt >> st) << 1) << st) | j;
    b_addr = a_addr | span;
    k = j << (SW'(AW - 1) - st);
    issue = state == COMPUTE && cnt < AW'(N / 2);
    ready = state == IDLE || state == LOAD;
    w_im = inv_r ? sin_t[k] : -sin_t[k];
  end
  fft_butterfly #(.DW(DW), .TW(TW_WIDTH), .TAG_W(2 * AW), .SCALE_EN(SCALE_EN)) u_bf (
    .clk(clk),
    .n_rst(n_rst),
    .valid_in(issue),
    .a_re(a_w[2*DW-1:DW]),
    .a_im(a_w[DW-1:0]),
    .b_re(b_w[2*DW-1:DW]),
    .b_im(b_w[DW-1:0]),
    .w_re(cos_t[k]),
    .w_im(w_im),
    .tag_in({a_addr, b_addr}),
    .valid_out(bf_v),
    .a_out(ya),
    .b_out(yb),
    .tag_out(wtag),
    .ovf_out(bf_ovf)
  );
  // Sample memory: bit-reversed load port plus the two butterfly write-back ports; never reset
  always_ff @(posedge clk) begin
    if (en && ready) mem[AW'(bit_rev(8'(cnt), AW))] <= cplx_data_in;
    if (bf_v) begin
      mem[wtag[2*AW-1:AW]] <= ya;
      mem[wtag[AW-1:0]] <= yb;
    end
  end
  // Frame sequencer: load, log2(N) stages of N/2 issues plus drain, then natural-order unload
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt <= '0;
      st <= '0;
      inv_r <= 1'b0;
      ovf <= 1'b0;
      en_out <= 1'b0;
      last_out <= 1'b0;
      cplx_data_out <= '0;
    end else begin
      en_out <= state == UNLOAD;
      last_out <= state == UNLOAD && cnt == AW'(N - 1);
      cplx_data_out <= state == UNLOAD ? mem[cnt] : '0;
      if (bf_v && bf_ovf) ovf <= 1'b1;
      case (state)
        IDLE: if (en) begin
          inv_r <= inv;
          ovf <= 1'b0;
          cnt <= AW'(1);
          state <= LOAD;
        end
        LOAD: if (en) begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(N - 1)) state <= COMPUTE;
        end
        COMPUTE: if (cnt == AW'(N / 2 + BF_LAT - 1)) begin
          cnt <= '0;
          st <= st == SW'(AW - 1) ? '0 : st + 1'b1;
          if (st == SW'(AW - 1)) state <= UNLOAD;
        end else cnt <= cnt + 1'b1;
        UNLOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(N - 1)) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_iter.sv
// tb_fft_iter: directed frames against a queue of expected bins for the 8-point fft_iter
module tb_fft_iter;
  localparam int N = 8;
  typedef struct {int re; int im; int tol;} exp_t;
  logic clk = 1'b0, n_rst = 1'b1, en = 1'b0, en_ns = 1'b0, inv = 1'b0;
  logic [31:0] din = '0;
  logic ready, en_out, last_out, ovf, ready_ns, en_out_ns, last_ns, ovf_ns;
  logic [31:0] dout, dout_ns;
  int errors = 0, checks = 0, cyc = 0, last_edge = 0;
  int frames_done = 0, bin_idx = 0, ns_done = 0, ns_idx = 0, ns_re = 0, ns_im = 0;
  exp_t sbq[$];
  exp_t e;
  logic [31:0] fr [8];
  int fre [8] = '{128, 91, 0, -91, -128, -91, 0, 91};
  int fim [8] = '{0, -91, -128, -91, 0, 91, 128, 91};

  fft_iter #(.N(N), .DATA_WIDTH(16), .TW_WIDTH(16), .SCALE_EN(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .cplx_data_in(din), .inv(inv), .ready(ready),
    .cplx_data_out(dout), .en_out(en_out), .last_out(last_out), .ovf(ovf));
  fft_iter #(.N(N), .DATA_WIDTH(16), .TW_WIDTH(16), .SCALE_EN(1'b0)) dut_ns (
    .clk(clk), .n_rst(n_rst), .en(en_ns), .cplx_data_in(din), .inv(inv), .ready(ready_ns),
    .cplx_data_out(dout_ns), .en_out(en_out_ns), .last_out(last_ns), .ovf(ovf_ns));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v, input int tol);
    checks++;
    assert (obs - exp_v <= tol && exp_v - obs <= tol)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp_v, tol);
    end
  endtask

  function automatic logic [31:0] cx(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  task automatic push(input int re, input int im, input int tol);
    sbq.push_back('{re, im, tol});
  endtask

  task automatic send_frame(input logic [31:0] s [8], input logic iv, input bit gaps, input bit ns, input int from);
    for (int i = from; i < N; i++) begin
      @(negedge clk);
      if (ns) en_ns = 1'b1; else en = 1'b1;
      din = s[i];
      inv = (gaps && i > 0) ? ~iv : iv;
      if (i == N - 1) last_edge = cyc + 1;
      if (gaps) begin
        @(negedge clk);
        en = 1'b0;
        din = $urandom;
        inv = ~iv;
      end
    end
    @(negedge clk);
    en = 1'b0;
    en_ns = 1'b0;
  endtask

  task automatic wait_main(input int target);
    for (int i = 0; i < 200 && frames_done < target; i++) @(negedge clk);
    chk("frame_done", frames_done, target, 0);
    chk("dout_idle", int'(dout), 0, 0);
  endtask

  task automatic wait_ns(input int target);
    for (int i = 0; i < 200 && ns_done < target; i++) @(negedge clk);
    chk("ns_frame_done", ns_done, target, 0);
  endtask

  // Scoreboard side: every valid bin is popped and compared, with latency and last_out checks
  always @(negedge clk) begin
    if (en_out) begin
      if (bin_idx == 0) chk("latency", cyc - last_edge, 19, 0);
      chk("last_out", int'(last_out), int'(bin_idx == N - 1), 0);
      chk("sb_nonempty", int'(sbq.size() > 0), 1, 0);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("bin_re", $signed(dout[31:16]), e.re, e.tol);
        chk("bin_im", $signed(dout[15:0]), e.im, e.tol);
      end
      bin_idx = last_out ? 0 : bin_idx + 1;
      if (last_out) frames_done++;
    end
  end

  always @(negedge clk) begin
    if (en_out_ns) begin
      if (ns_idx == 0) begin
        ns_re = $signed(dout_ns[31:16]);
        ns_im = $signed(dout_ns[15:0]);
      end
      ns_idx = last_ns ? 0 : ns_idx + 1;
      if (last_ns) ns_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #3 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1, 0);
    chk("rst_en_out", int'(en_out), 0, 0);
    chk("rst_last", int'(last_out), 0, 0);
    chk("rst_ovf", int'(ovf), 0, 0);
    chk("rst_dout", int'(dout), 0, 0);
    n_rst = 1'b1;
    // impulse of 1000 at x[0]: flat spectrum of 125
    for (int i = 0; i < N; i++) fr[i] = cx(i == 0 ? 1000 : 0, 0);
    for (int i = 0; i < N; i++) push(125, 0, 0);
    send_frame(fr, 1'b0, 1'b0, 1'b0, 0);
    wait_main(1);
    chk("ovf_impulse", int'(ovf), 0, 0);
    chk("ready_after", int'(ready), 1, 0);
    // constant 800: all energy in bin 0
    for (int i = 0; i < N; i++) fr[i] = cx(800, 0);
    for (int i = 0; i < N; i++) push(i == 0 ? 800 : 0, 0, 1);
    send_frame(fr, 1'b0, 1'b0, 1'b0, 0);
    wait_main(2);
    // x[1]=1024, forward then inverse
    for (int i = 0; i < N; i++) fr[i] = cx(i == 1 ? 1024 : 0, 0);
    for (int i = 0; i < N; i++) push(fre[i], fim[i], 1);
    send_frame(fr, 1'b0, 1'b0, 1'b0, 0);
    wait_main(3);
    for (int i = 0; i < N; i++) push(fre[i], -fim[i], 1);
    send_frame(fr, 1'b1, 1'b0, 1'b0, 0);
    wait_main(4);
    // gapped load with inv wiggling, then en pulses while busy
    for (int i = 0; i < N; i++) push(fre[i], fim[i], 1);
    send_frame(fr, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b1;
      din = $urandom;
      chk("ready_busy", int'(ready), 0, 0);
      @(negedge clk);
      en = 1'b0;
    end
    wait_main(5);
    // unscaled full-scale DC saturates bin 0 and raises ovf
    for (int i = 0; i < N; i++) fr[i] = cx(32767, 0);
    send_frame(fr, 1'b0, 1'b0, 1'b1, 0);
    wait_ns(1);
    chk("sat_bin0_re", ns_re, 32767, 0);
    chk("sat_bin0_im", ns_im, 0, 0);
    chk("sat_ovf", int'(ovf_ns), 1, 0);
    repeat (3) @(negedge clk);
    chk("ovf_idle_hold", int'(ovf_ns), 1, 0);
    for (int i = 0; i < N; i++) fr[i] = cx(i == 0 ? 1000 : 0, 0);
    @(negedge clk);
    en_ns = 1'b1;
    din = fr[0];
    inv = 1'b0;
    @(negedge clk);
    en_ns = 1'b0;
    chk("ovf_cleared", int'(ovf_ns), 0, 0);
    send_frame(fr, 1'b0, 1'b0, 1'b1, 1);
    wait_ns(2);
    chk("ns_impulse_re", ns_re, 1000, 0);
    chk("ns_ovf_clean", int'(ovf_ns), 0, 0);
    // reset in the middle of COMPUTE aborts the frame
    send_frame(fr, 1'b0, 1'b0, 1'b0, 0);
    repeat (6) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_ready", int'(ready), 1, 0);
    chk("midrst_en_out", int'(en_out), 0, 0);
    chk("midrst_dout", int'(dout), 0, 0);
    chk("midrst_last", int'(last_out), 0, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_partial", frames_done, 5, 0);
    for (int i = 0; i < N; i++) push(125, 0, 0);
    send_frame(fr, 1'b0, 1'b0, 1'b0, 0);
    wait_main(6);
    chk("sb_drained", sbq.size(), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
